// File: rtl/pcie_ss_axis_stream_checker.sv
// Compares a DUT AXI-Stream against buffered expected beats, with a verdict one cycle after the deciding beat.
// Both streams stall outside RUN; PCIE_SS_AXIS_CHK_BP_EN adds LFSR backpressure on dut_tready.
module pcie_ss_axis_stream_checker #(
    parameter int DATA_WIDTH = 512,
    parameter int EXP_DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    exp_tvalid,
    output logic                    exp_tready,
    input  logic [DATA_WIDTH-1:0]   exp_tdata,
    input  logic [DATA_WIDTH/8-1:0] exp_tkeep,
    input  logic                    exp_tlast,
    input  logic                    dut_tvalid,
    output logic                    dut_tready,
    input  logic [DATA_WIDTH-1:0]   dut_tdata,
    input  logic [DATA_WIDTH/8-1:0] dut_tkeep,
    input  logic                    dut_tlast,
    input  logic [15:0]             num_pkts,
    output logic [15:0]             pkt_cnt,
    output logic [31:0]             err_beat,
    output logic                    error,
    output logic                    done
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(EXP_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t                state;
    logic [15:0]           num_lat;
    logic [31:0]           beat_cnt;
    logic [AW:0]           count;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem_data [EXP_DEPTH];
    logic [KW-1:0]         mem_keep [EXP_DEPTH];
    logic                  mem_last [EXP_DEPTH];

    logic full, empty, push, pop, bp_ok, data_bad, mismatch;

    assign full       = (count == (AW+1)'(EXP_DEPTH));
    assign empty      = (count == '0);
    // Ready depends only on occupancy, so a full FIFO never pushes even when popping that cycle.
    assign exp_tready = !full && (state == RUN);
    assign dut_tready = !empty && (state == RUN) && bp_ok;
    assign push       = exp_tvalid && exp_tready;
    assign pop        = dut_tvalid && dut_tready;

`ifdef PCIE_SS_AXIS_CHK_BP_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 16'hACE1;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign bp_ok = lfsr[0];
`else
    assign bp_ok = 1'b1;
`endif

    // Bytes the expected stream marks as null are don't-care.
    always_comb begin
        data_bad = 1'b0;
        for (int i = 0; i < KW; i++) begin
            if (mem_keep[rd_ptr][i] && (mem_data[rd_ptr][8*i +: 8] != dut_tdata[8*i +: 8]))
                data_bad = 1'b1;
        end
    end

    assign mismatch = data_bad || (mem_keep[rd_ptr] != dut_tkeep) || (mem_last[rd_ptr] != dut_tlast);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= exp_tdata;
            mem_keep[wr_ptr] <= exp_tkeep;
            mem_last[wr_ptr] <= exp_tlast;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            num_lat  <= '0;
            beat_cnt <= '0;
            pkt_cnt  <= '0;
            err_beat <= '0;
            error    <= 1'b0;
            done     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);

            if (pop) begin
                if (beat_cnt != 32'hFFFF_FFFF)
                    beat_cnt <= beat_cnt + 32'd1;
                if (dut_tlast)
                    pkt_cnt <= pkt_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (num_pkts != 16'd0) begin
                        num_lat <= num_pkts;
                        done    <= 1'b0;
                        state   <= RUN;
                    end else begin
                        done <= 1'b1;
                    end
                end
                RUN: begin
                    if (pop) begin
                        if (mismatch) begin
                            state    <= ERR;
                            error    <= 1'b1;
                            done     <= 1'b1;
                            err_beat <= beat_cnt;
                        end else if (dut_tlast && (pkt_cnt + 16'd1 == num_lat)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Any traffic after the last expected packet is an error.
                    if (dut_tvalid) begin
                        state    <= ERR;
                        error    <= 1'b1;
                        err_beat <= beat_cnt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pcie_ss_axis_stream_checker.sv
// Directed bench for pcie_ss_axis_stream_checker (DATA_WIDTH=512, EXP_DEPTH=16).
module tb_pcie_ss_axis_stream_checker;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         exp_tvalid = 1'b0;
    logic         exp_tready;
    logic [511:0] exp_tdata = '0;
    logic [63:0]  exp_tkeep = '0;
    logic         exp_tlast = 1'b0;
    logic         dut_tvalid = 1'b0;
    logic         dut_tready;
    logic [511:0] dut_tdata = '0;
    logic [63:0]  dut_tkeep = '0;
    logic         dut_tlast = 1'b0;
    logic [15:0]  num_pkts = '0;
    logic [15:0]  pkt_cnt;
    logic [31:0]  err_beat;
    logic         error;
    logic         done;

    int checks = 0;
    int errors = 0;
    logic saw_bp = 1'b0;
    logic [511:0] d;

    pcie_ss_axis_stream_checker #(.DATA_WIDTH(512), .EXP_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .exp_tvalid(exp_tvalid), .exp_tready(exp_tready), .exp_tdata(exp_tdata),
        .exp_tkeep(exp_tkeep), .exp_tlast(exp_tlast),
        .dut_tvalid(dut_tvalid), .dut_tready(dut_tready), .dut_tdata(dut_tdata),
        .dut_tkeep(dut_tkeep), .dut_tlast(dut_tlast),
        .num_pkts(num_pkts), .pkt_cnt(pkt_cnt), .err_beat(err_beat),
        .error(error), .done(done)
    );

    always #5 clk = ~clk;

    // Backpressure seen: DUT offers a beat, FIFO holds data, checker still running, yet not ready.
    always @(negedge clk)
        if (!rst && !done && dut_tvalid && dut.count != 0 && !dut_tready)
            saw_bp <= 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] bd(input int i);
        logic [511:0] r;
        for (int b = 0; b < 64; b++)
            r[8*b +: 8] = 8'(i * 7 + b * 3 + 1);
        return r;
    endfunction

    task automatic do_reset(input logic [15:0] n);
        @(negedge clk);
        rst = 1'b1; num_pkts = n; exp_tvalid = 1'b0; dut_tvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_exp(input logic [511:0] dd, input logic [63:0] k, input logic l);
        int n;
        @(negedge clk);
        exp_tvalid = 1'b1; exp_tdata = dd; exp_tkeep = k; exp_tlast = l;
        n = 0;
        while (!exp_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("exp_tready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 exp_tvalid = 1'b0;
    endtask

    task automatic send_dut(input logic [511:0] dd, input logic [63:0] k, input logic l);
        int n;
        @(negedge clk);
        dut_tvalid = 1'b1; dut_tdata = dd; dut_tkeep = k; dut_tlast = l;
        n = 0;
        while (!dut_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("dut_tready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 dut_tvalid = 1'b0;
    endtask

    initial begin
        // Reset values, then IDLE->RUN on the first cycle.
        do_reset(16'd4);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err_beat", err_beat, 0);
        chk("rst_exp_tready", exp_tready, 0);
        chk("rst_dut_tready", dut_tready, 0);
        chk("rst_beat_cnt", dut.beat_cnt, 0);
        @(negedge clk);
        chk("run_exp_tready", exp_tready, 1);
        chk("run_empty_dut_tready", dut_tready, 0);

        // Four clean 3-beat packets.
        for (int i = 0; i < 12; i++) push_exp(bd(i), '1, (i % 3) == 2);
        for (int i = 0; i < 12; i++) send_dut(bd(i), '1, (i % 3) == 2);
        @(negedge clk);
        chk("pass_done", done, 1);
        chk("pass_error", error, 0);
        chk("pass_pkt_cnt", pkt_cnt, 4);
        chk("pass_beat_cnt", dut.beat_cnt, 12);
        chk("pass_dut_tready", dut_tready, 0);

        // Byte 0 of beat 5 corrupted; later garbage must not move err_beat.
        do_reset(16'd4);
        for (int i = 0; i < 12; i++) push_exp(bd(i), '1, (i % 3) == 2);
        for (int i = 0; i < 5; i++) send_dut(bd(i), '1, (i % 3) == 2);
        chk("mm_pre_done", done, 0);
        d = bd(5);
        d[7:0] = ~d[7:0];
        send_dut(d, '1, 1'b1);
        @(negedge clk);
        chk("mm_done", done, 1);
        chk("mm_error", error, 1);
        chk("mm_err_beat", err_beat, 5);
        chk("mm_dut_tready", dut_tready, 0);
        dut_tvalid = 1'b1; dut_tdata = '1; dut_tkeep = '1; dut_tlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mm_hold_tready", dut_tready, 0);
        end
        dut_tvalid = 1'b0;
        chk("mm_sticky_err_beat", err_beat, 5);
        chk("mm_sticky_error", error, 1);

        // Null bytes ignored.
        do_reset(16'd1);
        push_exp(bd(20), 64'h0F, 1'b1);
        d = bd(20);
        d[511:32] = ~d[511:32];
        send_dut(d, 64'h0F, 1'b1);
        @(negedge clk);
        chk("keep_done", done, 1);
        chk("keep_error", error, 0);
        chk("keep_pkt_cnt", pkt_cnt, 1);

        // tkeep difference alone is an error.
        do_reset(16'd1);
        push_exp(bd(3), 64'h0F, 1'b1);
        send_dut(bd(3), 64'h1F, 1'b1);
        @(negedge clk);
        chk("keepdiff_error", error, 1);
        chk("keepdiff_err_beat", err_beat, 0);

        // tlast difference alone is an error, at beat index 1.
        do_reset(16'd1);
        push_exp(bd(0), '1, 1'b0);
        push_exp(bd(1), '1, 1'b0);
        send_dut(bd(0), '1, 1'b0);
        send_dut(bd(1), '1, 1'b1);
        @(negedge clk);
        chk("lastdiff_error", error, 1);
        chk("lastdiff_err_beat", err_beat, 1);

        // Fill to 16, then pop while a 17th beat is offered: no push.
        do_reset(16'd2);
        for (int i = 0; i < 16; i++) push_exp(bd(i), '1, (i % 8) == 7);
        @(negedge clk);
        chk("full_exp_tready", exp_tready, 0);
        chk("full_count", dut.count, 16);
        exp_tvalid = 1'b1; exp_tdata = bd(99); exp_tkeep = '1; exp_tlast = 1'b0;
        send_dut(bd(0), '1, 1'b0);
        exp_tvalid = 1'b0;
        @(negedge clk);
        chk("pop_exp_tready", exp_tready, 1);
        chk("pop_no_push_count", dut.count, 15);
        for (int i = 1; i < 16; i++) send_dut(bd(i), '1, (i % 8) == 7);
        @(negedge clk);
        chk("full_run_done", done, 1);
        chk("full_run_error", error, 0);
        chk("full_run_pkt_cnt", pkt_cnt, 2);

        // Extra traffic after DONE.
        do_reset(16'd1);
        for (int i = 0; i < 3; i++) push_exp(bd(i + 40), '1, i == 2);
        for (int i = 0; i < 3; i++) send_dut(bd(i + 40), '1, i == 2);
        @(negedge clk);
        chk("extra_pre_done", done, 1);
        chk("extra_pre_error", error, 0);
        dut_tvalid = 1'b1; dut_tdata = bd(0); dut_tkeep = '1; dut_tlast = 1'b0;
        @(negedge clk);
        dut_tvalid = 1'b0;
        chk("extra_error", error, 1);
        chk("extra_err_beat", err_beat, 3);
        chk("extra_done", done, 1);

        // num_pkts == 0 stays IDLE with done.
        do_reset(16'd0);
        @(negedge clk);
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_exp_tready", exp_tready, 0);
        chk("zero_error", error, 0);

        // Reset mid-packet discards buffered beats, then a clean 2-packet run.
        do_reset(16'd2);
        for (int i = 0; i < 3; i++) push_exp(bd(i + 60), '1, i == 2);
        send_dut(bd(60), '1, 1'b0);
        do_reset(16'd2);
        saw_bp = 1'b0;
        @(negedge clk);
        chk("abort_count", dut.count, 0);
        chk("abort_dut_tready", dut_tready, 0);
        chk("abort_pkt_cnt", pkt_cnt, 0);
        for (int i = 0; i < 6; i++) push_exp(bd(i + 80), '1, (i % 3) == 2);
        for (int i = 0; i < 6; i++) send_dut(bd(i + 80), '1, (i % 3) == 2);
        @(negedge clk);
        chk("abort_run_done", done, 1);
        chk("abort_run_error", error, 0);
        chk("abort_run_pkt_cnt", pkt_cnt, 2);
        chk("abort_run_beat_cnt", dut.beat_cnt, 6);
`ifdef PCIE_SS_AXIS_CHK_BP_EN
        chk("bp_seen", saw_bp, 1);
`else
        chk("bp_seen", saw_bp, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcie_ss_axis_stream_checker.md
PCIE_SS_AXIS_STREAM_CHECKER -- requirements
Module: pcie_ss_axis_stream_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: tdata width in bits; legal values 256, 512, 1024, 2048.
REQ-002 SHALL have parameter EXP_DEPTH, default 16: expected-beat FIFO depth; power of two, 4..64.
REQ-003 SHALL have ports:
- clk  in  1  sole clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- exp_tvalid  in  1  expected-stream beat valid.
- exp_tready  out  1  expected-stream ready.
- exp_tdata  in  DATA_WIDTH  expected data.
- exp_tkeep  in  DATA_WIDTH/8  expected byte enables.
- exp_tlast  in  1  expected end of packet.
- dut_tvalid  in  1  DUT-output beat valid.
- dut_tready  out  1  DUT-output ready.
- dut_tdata  in  DATA_WIDTH  DUT data.
- dut_tkeep  in  DATA_WIDTH/8  DUT byte enables.
- dut_tlast  in  1  DUT end of packet.
- num_pkts  in  16  packets to check; sampled in IDLE.
- pkt_cnt  out  16  packets compared so far.
- err_beat  out  32  beat index of first error.
- error  out  1  sticky error flag.
- done  out  1  check finished, pass or fail.

Function
REQ-004 SHALL buffer expected beats (tdata, tkeep, tlast) in an EXP_DEPTH-entry FIFO.
REQ-005 SHALL drive exp_tready = FIFO not full AND state==RUN.
REQ-006 SHALL NOT accept a push when the FIFO is full, even if a pop occurs in the same cycle.
REQ-007 SHALL drive dut_tready = FIFO not empty AND state==RUN, further gated per REQ-019.
REQ-008 SHALL compare one beat per dut_tvalid&&dut_tready cycle against the FIFO head and pop the head in that cycle.
REQ-009 SHALL declare a beat mismatched if any of the following differ: tkeep, tlast, or any data byte whose tkeep bit is 1; bytes with tkeep=0 SHALL be ignored.
REQ-010 SHALL increment a 32-bit beat counter per compared beat, saturating at 0xFFFFFFFF.
REQ-011 SHALL increment pkt_cnt on each compared beat with dut_tlast=1.
REQ-012 SHALL implement states IDLE, RUN, DONE, ERR:
- IDLE->RUN: first cycle after reset, when num_pkts!=0 (num_pkts latched).
- IDLE with num_pkts==0: stays IDLE with done=1.
- RUN->DONE: compared tlast beat that brings pkt_cnt to the latched num_pkts.
- RUN->ERR: any mismatch.
- DONE->ERR: dut_tvalid=1 while in DONE (extra traffic).
- DONE and ERR: terminal until reset.
REQ-013 SHALL, on entry to ERR, set error=1 and capture err_beat = beat index of the offending beat (0-based); for extra traffic, err_beat = beat counter value.
REQ-014 SHALL assert done in DONE and ERR, one cycle after the deciding beat.
REQ-015 SHALL hold dut_tready=0 and exp_tready=0 in IDLE, DONE and ERR.
REQ-016 SHALL treat a later mismatch after ERR as no-op; err_beat keeps the first value.

Reset
REQ-017 SHALL, while rst=1 at a clk edge, clear the FIFO, beat counter, pkt_cnt, err_beat, error and done to 0 and enter IDLE.
REQ-018 SHALL abort a packet in progress on reset mid-packet, discarding all buffered expected beats.

Configuration
REQ-019 With PCIE_SS_AXIS_CHK_BP_EN defined, SHALL AND dut_tready with bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 on reset; advances every cycle). Without the macro, there SHALL be no LFSR and dut_tready follows REQ-007 only.

Verification
REQ-020 Reset with num_pkts=4, 4 identical 3-beat packets on both streams -> done=1, error=0, pkt_cnt=4, beat counter=12.
REQ-021 Same as REQ-020 but DUT beat 5 data byte 0 flipped -> error=1, err_beat=5, done=1 the cycle after beat 5, dut_tready=0 thereafter.
REQ-022 tkeep=0x0F on a beat with garbage in bytes 4..63 on the DUT side only (DATA_WIDTH=512) -> no error.
REQ-023 Expected stream pushes 16 beats with DUT idle (EXP_DEPTH=16) -> exp_tready=0 after the 16th push; one DUT beat accepted -> exp_tready=1 the next cycle.
REQ-024 num_pkts=1, one packet completes, then dut_tvalid=1 -> error=1, err_beat=beat count of first packet.
REQ-025 With PCIE_SS_AXIS_CHK_BP_EN defined, rst pulsed mid-packet, then a 2-packet run -> pass with pkt_cnt=2, and dut_tready is observed low at least once.
